// File: rtl/c17_bist_ctrl.sv
// BIST sequencer for the c17 benchmark: drives LFSR patterns into an external CUT,
// compacts its responses into a MISR and compares the final signature to a golden value.
module c17_bist_ctrl #(
  parameter int PAT_W  = 5,
  parameter int RESP_W = 2,
  parameter int LFSR_W = 8,
  parameter int MISR_W = 8,
  parameter int CNT_W  = 8,
  parameter int SETTLE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [LFSR_W-1:0] seed,
  input  logic [CNT_W-1:0]  num_patterns,
  input  logic [MISR_W-1:0] golden_sig,
  input  logic [RESP_W-1:0] resp_in,
  output logic [PAT_W-1:0]  pat_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [MISR_W-1:0] signature
);

  localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SEED, S_APPLY, S_CAPTURE, S_COMPARE, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [LFSR_W-1:0]   lfsr_q, lfsr_d, lfsr_step, seed_eff;
  logic [MISR_W-1:0]   misr_q, misr_d, misr_step;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [SET_W-1:0]    settle_q, settle_d;
  logic [PAT_W-1:0]    pat_q, pat_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic [MISR_W-1:0]   sig_q, sig_d;

  // An all-zero seed would lock the LFSR, so it is promoted to 1.
  assign seed_eff  = (seed == '0) ? LFSR_W'(1) : seed;
  assign lfsr_step = {lfsr_q[LFSR_W-2:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

  // Response bit i folds into MISR stage i after the shift.
  always_comb begin
    misr_step = {misr_q[MISR_W-2:0], misr_q[7] ^ misr_q[5] ^ misr_q[4] ^ misr_q[3]};
    for (int i = 0; i < RESP_W; i++) begin
      misr_step[i] = misr_step[i] ^ resp_in[i];
    end
  end

  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    misr_d   = misr_q;
    cnt_d    = cnt_q;
    settle_d = settle_q;
    pat_d    = pat_q;
    done_d   = 1'b0;
    pass_d   = pass_q;
    sig_d    = sig_q;

    case (state_q)
      S_IDLE: begin
        pat_d = '0;
        if (start && !abort) state_d = S_SEED;
      end
      S_SEED: begin
        lfsr_d = seed_eff;
        misr_d = '0;
        cnt_d  = '0;
        pass_d = 1'b0;
        if (num_patterns == '0) begin
          state_d = S_COMPARE;
        end else begin
          state_d  = S_APPLY;
          settle_d = '0;
          pat_d    = seed_eff[PAT_W-1:0];
        end
      end
      S_APPLY: begin
        if (settle_q == SETTLE_LAST) state_d = S_CAPTURE;
        else settle_d = settle_q + SET_W'(1);
      end
      S_CAPTURE: begin
        misr_d = misr_step;
        lfsr_d = lfsr_step;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == num_patterns - CNT_W'(1)) begin
          state_d = S_COMPARE;
        end else begin
          state_d  = S_APPLY;
          settle_d = '0;
          pat_d    = lfsr_step[PAT_W-1:0];
        end
      end
      S_COMPARE: begin
        sig_d   = misr_q;
        pass_d  = (misr_q == golden_sig);
        done_d  = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        pat_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort outranks every in-run transition and discards the partial result.
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      pat_d   = '0;
      done_d  = 1'b0;
      pass_d  = 1'b0;
      sig_d   = sig_q;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      lfsr_q   <= '0;
      misr_q   <= '0;
      cnt_q    <= '0;
      settle_q <= '0;
      pat_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      sig_q    <= '0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      misr_q   <= misr_d;
      cnt_q    <= cnt_d;
      settle_q <= settle_d;
      pat_q    <= pat_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      sig_q    <= sig_d;
    end
  end

  assign pat_out   = pat_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign signature = sig_q;

endmodule

// File: tb/tb_c17_bist_ctrl.sv
// Bench for c17_bist_ctrl: directed runs against a c17 gate model, with expected
// patterns, signatures and pass flags queued at stimulus time and popped on DUT output.
module tb_c17_bist_ctrl;

  localparam int TB_SETTLE = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] seed = '0;
  logic [7:0] num_patterns = '0;
  logic [7:0] golden_sig = '0;
  logic [1:0] resp_in;
  logic [4:0] pat_out;
  logic       busy, done, pass;
  logic [7:0] signature;

  logic [1:0] resp_const = 2'b11;
  logic       use_cut = 1'b0;
  logic       stuck22 = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  logic [4:0] exp_pat_q[$];
  logic [7:0] exp_sig_q[$];
  logic       exp_pass_q[$];
  logic [7:0] last_sig;
  logic [7:0] ref_sig;

  always #5 clk = ~clk;

  c17_bist_ctrl #(.SETTLE(TB_SETTLE)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .seed(seed),
    .num_patterns(num_patterns), .golden_sig(golden_sig), .resp_in(resp_in),
    .pat_out(pat_out), .busy(busy), .done(done), .pass(pass), .signature(signature)
  );

  // c17 netlist: inputs 1,2,3,6,7 -> p[0..4]; returns {23, 22}.
  function automatic logic [1:0] c17(input logic [4:0] p, input logic sa0_22);
    logic n10, n11, n16, n19, o22, o23;
    n10 = ~(p[0] & p[2]);
    n11 = ~(p[2] & p[3]);
    n16 = ~(p[1] & n11);
    n19 = ~(n11 & p[4]);
    o22 = ~(n10 & n16);
    o23 = ~(n16 & n19);
    return {o23, sa0_22 ? 1'b0 : o22};
  endfunction

  function automatic logic [7:0] lfsr_next(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  function automatic logic [7:0] misr_next(input logic [7:0] m, input logic [1:0] r);
    logic [7:0] n;
    n = {m[6:0], m[7] ^ m[5] ^ m[4] ^ m[3]};
    n[0] = n[0] ^ r[0];
    n[1] = n[1] ^ r[1];
    return n;
  endfunction

  function automatic logic [1:0] resp_model(input logic [4:0] p);
    return use_cut ? c17(p, stuck22) : resp_const;
  endfunction

  assign resp_in = resp_model(pat_out);

  function automatic logic [7:0] model_sig(input logic [7:0] sd, input int n);
    logic [7:0] l, m;
    l = (sd == 8'h00) ? 8'h01 : sd;
    m = 8'h00;
    for (int k = 0; k < n; k++) begin
      m = misr_next(m, resp_model(l[4:0]));
      l = lfsr_next(l);
    end
    return m;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One complete run; patterns are checked at the start of each apply window.
  task automatic run_test(input logic [7:0] sd, input int n, input logic [7:0] gold);
    logic [7:0] l, m;
    bit got_done;
    int budget;
    l = (sd == 8'h00) ? 8'h01 : sd;
    m = 8'h00;
    for (int k = 0; k < n; k++) begin
      exp_pat_q.push_back(l[4:0]);
      m = misr_next(m, resp_model(l[4:0]));
      l = lfsr_next(l);
    end
    exp_sig_q.push_back(m);
    exp_pass_q.push_back(m == gold);

    @(negedge clk);
    seed = sd; num_patterns = n[7:0]; golden_sig = gold; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    got_done = 1'b0;
    budget = n * (TB_SETTLE + 1) + 10;
    for (int e = 1; e <= budget && !got_done; e++) begin
      @(posedge clk); #1;
      if (((e - 1) % (TB_SETTLE + 1) == 0) && ((e - 1) / (TB_SETTLE + 1) < n))
        check("pat_out", pat_out, exp_pat_q.pop_front());
      if (done) begin
        got_done = 1'b1;
        check("done_latency", e, n * (TB_SETTLE + 1) + 2);
        check("busy_in_done", busy, 1);
        last_sig = exp_sig_q.pop_front();
        check("signature", signature, last_sig);
        check("pass", pass, exp_pass_q.pop_front());
      end
    end
    check("done_seen", got_done, 1);
    @(posedge clk); #1;
    check("done_one_cycle", done, 0);
    check("busy_after", busy, 0);
    check("pat_idle", pat_out, 0);
  endtask

  initial begin
    int done_cnt;
    #1;
    check("rst_pat", pat_out, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_sig", signature, 0);
    @(negedge clk); rst_n = 1'b1;

    // Single pattern with constant response 2'b11.
    run_test(8'h01, 1, 8'h03);
    check("single_sig_const", signature, 8'h03);
    check("single_pass_const", pass, 1);

    // Asynchronous reset in the middle of APPLY.
    @(negedge clk);
    seed = 8'h01; num_patterns = 8'd10; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1;
    check("mid_apply_pat", pat_out, 5'h01);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_pat", pat_out, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_done", done, 0);
    check("async_rst_pass", pass, 0);
    check("async_rst_sig", signature, 0);
    @(negedge clk); rst_n = 1'b1;

    // Two patterns, matching and mismatching golden.
    run_test(8'h01, 2, 8'h05);
    check("two_sig_const", signature, 8'h05);
    check("two_pass_const", pass, 1);
    run_test(8'h01, 2, 8'h06);
    check("two_fail_const", pass, 0);

    // Zero seed with N=0 and N=1.
    run_test(8'h00, 0, 8'h00);
    check("n0_sig", signature, 8'h00);
    run_test(8'h00, 0, 8'h12);
    run_test(8'h00, 1, 8'h03);

    // Abort during the second APPLY of a 10-pattern run.
    run_test(8'h01, 2, 8'h05);
    @(negedge clk);
    seed = 8'h01; num_patterns = 8'd10; golden_sig = 8'h00; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("second_pattern", pat_out, 5'h02);
    @(negedge clk) abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_pat", pat_out, 0);
    check("abort_pass", pass, 0);
    check("abort_sig_held", signature, last_sig);
    done_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (done) done_cnt++;
    end
    check("abort_no_done", done_cnt, 0);
    check("abort_stays_idle", busy, 0);

    // Abort together with start in IDLE keeps the block idle.
    @(negedge clk); start = 1'b1; abort = 1'b1;
    @(posedge clk); #1 start = 1'b0; abort = 1'b0;
    check("abort_start_idle", busy, 0);
    run_test(8'h3C, 7, 8'h00);

    // Full c17 run, then with output 22 stuck at 0.
    use_cut = 1'b1;
    stuck22 = 1'b0;
    ref_sig = model_sig(8'hA5, 255);
    run_test(8'hA5, 255, ref_sig);
    check("c17_pass", pass, 1);
    stuck22 = 1'b1;
    run_test(8'hA5, 255, ref_sig);
    use_cut = 1'b0;
    stuck22 = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
